// File: rtl/pipe_defs.sv
// Shared encodings for the pipeline hazard logic: Tuse/Tnew codes, mult/div
// sequencer states and default unit latencies.
package pipe_defs;

    localparam logic [1:0] T_NONE = 2'd0;
    localparam logic [1:0] T_ALU  = 2'd1;
    localparam logic [1:0] T_LOAD = 2'd2;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;
    localparam int DEF_CNT_W       = 4;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    // One pipeline stage of progress toward result availability; saturates at T_NONE.
    function automatic logic [1:0] tnew_dec(input logic [1:0] t);
        return (t == T_NONE) ? T_NONE : (t - 2'd1);
    endfunction

endpackage

// File: rtl/md_busy_ctr.sv
// Mult/div busy sequencer: counts the unit's remaining busy cycles after an
// operation enters E. busy is combinational so the E cycle itself counts.
module md_busy_ctr
    import pipe_defs::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start,
    input  logic md_div,
    output logic busy
);

    md_state_e        state_r;
    md_state_e        state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W-1:0] load_s;

    assign load_s = md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

    // State and counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= MD_IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state and counter logic; a start seen while busy reloads the count.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            MD_IDLE: begin
                if (md_start) begin
                    cnt_nxt_s   = load_s;
                    state_nxt_s = MD_BUSY;
                end else begin
                    cnt_nxt_s   = '0;
                end
            end
            MD_BUSY: begin
                if (md_start) begin
                    cnt_nxt_s = load_s;
                end else if (cnt_r == CNT_W'(1)) begin
                    cnt_nxt_s   = '0;
                    state_nxt_s = MD_IDLE;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                cnt_nxt_s   = '0;
                state_nxt_s = MD_IDLE;
            end
        endcase
    end

    assign busy = md_start || (state_r == MD_BUSY);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/bubble controller for the 5-stage pipeline (Tuse/Tnew scheme).
// Optional mult/div sequencing is enabled by defining MD_UNIT_EN.
module hazard_stall_ctrl
    import pipe_defs::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] RS_D,
    input  logic [4:0] RT_D,
    input  logic [1:0] Tuse_rs,
    input  logic [1:0] Tuse_rt,
    input  logic [4:0] A3_D,
    input  logic [1:0] Tnew_D,
    input  logic       md_start_E,
    input  logic       md_div_E,
    input  logic       md_use_D,
    output logic       stall,
    output logic       flush_E,
    output logic       md_busy
);

    logic [4:0] a3_e_r;
    logic [4:0] a3_m_r;
    logic [1:0] tnew_e_r;
    logic [1:0] tnew_m_r;
    logic       stall_rs_s;
    logic       stall_rt_s;
    logic       stall_md_s;
    logic       md_busy_s;
    logic       stall_s;

    // Shadow copies of E/M destinations; a stall turns the E entry into a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            a3_e_r   <= 5'd0;
            tnew_e_r <= T_NONE;
            a3_m_r   <= 5'd0;
            tnew_m_r <= T_NONE;
        end else begin
            a3_m_r   <= a3_e_r;
            tnew_m_r <= tnew_dec(tnew_e_r);
            if (stall_s) begin
                a3_e_r   <= 5'd0;
                tnew_e_r <= T_NONE;
            end else begin
                a3_e_r   <= A3_D;
                tnew_e_r <= Tnew_D;
            end
        end
    end

    // Register-hazard detection; $0 is hard-wired and never creates a dependency.
    always_comb begin
        stall_rs_s = 1'b0;
        stall_rt_s = 1'b0;
        if (RS_D != 5'd0) begin
            stall_rs_s = ((RS_D == a3_e_r) && (Tuse_rs < tnew_e_r)) ||
                         ((RS_D == a3_m_r) && (Tuse_rs < tnew_m_r));
        end else begin
            stall_rs_s = 1'b0;
        end
        if (RT_D != 5'd0) begin
            stall_rt_s = ((RT_D == a3_e_r) && (Tuse_rt < tnew_e_r)) ||
                         ((RT_D == a3_m_r) && (Tuse_rt < tnew_m_r));
        end else begin
            stall_rt_s = 1'b0;
        end
    end

`ifdef MD_UNIT_EN
    md_busy_ctr #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_ctr (
        .clk      (clk),
        .reset    (reset),
        .md_start (md_start_E),
        .md_div   (md_div_E),
        .busy     (md_busy_s)
    );

    assign stall_md_s = md_use_D && md_busy_s;
`else
    logic md_unused_s;

    assign md_unused_s = md_start_E ^ md_div_E ^ md_use_D;
    assign md_busy_s   = 1'b0;
    assign stall_md_s  = 1'b0;
`endif

    assign stall_s = stall_rs_s || stall_rt_s || stall_md_s;
    assign stall   = stall_s;
    assign flush_E = stall_s;
    assign md_busy = md_busy_s;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios followed by
// randomized traffic, all compared against an instruction-level reference model.
module tb_hazard_stall_ctrl;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;
`ifdef MD_UNIT_EN
    localparam bit MD_ON = 1'b1;
`else
    localparam bit MD_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] RS_D, RT_D, A3_D;
    logic [1:0] Tuse_rs, Tuse_rt, Tnew_D;
    logic       md_start_E, md_div_E, md_use_D;
    logic       stall, flush_E, md_busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: what instruction sits in E and M, with its original Tnew.
    int e_dest = 0, e_tnew = 0, m_dest = 0, m_tnew = 0;
    int md_left = 0;

    hazard_stall_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .RS_D       (RS_D),
        .RT_D       (RT_D),
        .Tuse_rs    (Tuse_rs),
        .Tuse_rt    (Tuse_rt),
        .A3_D       (A3_D),
        .Tnew_D     (Tnew_D),
        .md_start_E (md_start_E),
        .md_div_E   (md_div_E),
        .md_use_D   (md_use_D),
        .stall      (stall),
        .flush_E    (flush_E),
        .md_busy    (md_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // An operand is blocked if a producer still needs more cycles than the consumer can wait.
    function automatic bit src_hazard(input int src, input int tuse);
        int m_left;
        m_left = (m_tnew > 0) ? m_tnew - 1 : 0;
        if (src == 0) return 1'b0;
        return ((src == e_dest) && (tuse < e_tnew)) || ((src == m_dest) && (tuse < m_left));
    endfunction

    function automatic bit exp_busy();
        return MD_ON && (md_start_E || (md_left > 0));
    endfunction

    function automatic bit exp_stall();
        return src_hazard(int'(RS_D), int'(Tuse_rs)) || src_hazard(int'(RT_D), int'(Tuse_rt)) ||
               (md_use_D && exp_busy());
    endfunction

    task automatic apply(input int rs, input int tuse_rs_v, input int rt, input int tuse_rt_v,
                         input int a3, input int tnew, input bit start, input bit div, input bit use_md);
        RS_D = 5'(rs);  Tuse_rs = 2'(tuse_rs_v);
        RT_D = 5'(rt);  Tuse_rt = 2'(tuse_rt_v);
        A3_D = 5'(a3);  Tnew_D  = 2'(tnew);
        md_start_E = start; md_div_E = div; md_use_D = use_md;
        @(negedge clk);
        if (!reset) begin
            chk("stall", int'(stall), int'(exp_stall()));
            chk("flush_E", int'(flush_E), int'(exp_stall()));
            chk("md_busy", int'(md_busy), int'(exp_busy()));
        end
    endtask

    task automatic tick();
        bit st;
        @(posedge clk);
        st = exp_stall();
        if (reset) begin
            e_dest = 0; e_tnew = 0; m_dest = 0; m_tnew = 0; md_left = 0;
        end else begin
            m_dest = e_dest; m_tnew = e_tnew;
            e_dest = st ? 0 : int'(A3_D);
            e_tnew = st ? 0 : int'(Tnew_D);
            if (md_start_E) md_left = md_div_E ? DIV_LAT : MULT_LAT;
            else if (md_left > 0) md_left--;
        end
        #1;
    endtask

    task automatic run_md(input bit div, input string tag, input int exp_cycles);
        int busy_cnt = 0;
        int stall_cnt = 0;
        apply(0, 3, 0, 3, 0, 0, 1'b1, div, 1'b1);
        busy_cnt += int'(md_busy); stall_cnt += int'(stall);
        tick();
        for (int i = 0; i < 20; i++) begin
            apply(0, 3, 0, 3, 0, 0, 1'b0, 1'b0, 1'b1);
            busy_cnt += int'(md_busy); stall_cnt += int'(stall);
            tick();
        end
        chk({tag, "_busy_cycles"}, busy_cnt, exp_cycles);
        chk({tag, "_stall_cycles"}, stall_cnt, exp_cycles);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        apply(0, 3, 0, 3, 0, 0, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        reset = 1'b0;
        apply(0, 3, 0, 3, 0, 0, 1'b0, 1'b0, 1'b0);
        chk("reset_stall", int'(stall), 0);
        chk("reset_busy", int'(md_busy), 0);
        tick();

        // lw $1 then add using $1 in E: one bubble
        apply(0, 3, 0, 3, 1, 2, 1'b0, 1'b0, 1'b0); tick();
        apply(1, 1, 0, 3, 3, 1, 1'b0, 1'b0, 1'b0);
        chk("lwuse_stall", int'(stall), 1);
        chk("lwuse_flush", int'(flush_E), 1);
        tick();
        apply(1, 1, 0, 3, 3, 1, 1'b0, 1'b0, 1'b0);
        chk("lwuse_release", int'(stall), 0);
        tick();

        // addu $2 then beq on $2 in D
        apply(0, 3, 0, 3, 2, 1, 1'b0, 1'b0, 1'b0); tick();
        apply(2, 0, 0, 3, 0, 0, 1'b0, 1'b0, 1'b0);
        chk("beq_stall", int'(stall), 1);
        tick();
        apply(2, 0, 0, 3, 0, 0, 1'b0, 1'b0, 1'b0);
        chk("beq_release", int'(stall), 0);
        tick();

        // $0 never stalls
        apply(0, 3, 0, 3, 0, 2, 1'b0, 1'b0, 1'b0); tick();
        apply(0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        chk("zero_reg", int'(stall), 0);
        tick();

        run_md(1'b0, "mult", MD_ON ? MULT_LAT + 1 : 0);
        run_md(1'b1, "div", MD_ON ? DIV_LAT + 1 : 0);

        // reset three cycles into a div with a load to $5 in flight
        apply(0, 3, 0, 3, 5, 2, 1'b1, 1'b1, 1'b0); tick();
        apply(0, 3, 0, 3, 5, 2, 1'b0, 1'b0, 1'b0); tick();
        apply(0, 3, 0, 3, 0, 0, 1'b0, 1'b0, 1'b0); tick();
        reset = 1'b1;
        apply(0, 3, 0, 3, 0, 0, 1'b0, 1'b0, 1'b0); tick();
        reset = 1'b0;
        apply(5, 0, 5, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        chk("rst_abort_busy", int'(md_busy), 0);
        chk("rst_abort_stall", int'(stall), 0);
        tick();

        // randomized traffic on a small register window to provoke matches
        for (int i = 0; i < 600; i++) begin
            bit st;
            reset = ($urandom_range(0, 59) == 0);
            st = (md_left == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 63) == 0);
            apply($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 2), st, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) == 0));
            tick();
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
